pipeline_controller: RTL
========================

Name: pipeline_controller

Overview:
Central stall/flush sequencer for the five-stage pipeline. It drives the write-enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and selects the PC source. It resolves load-use hazards, multi-cycle memory/IO accesses, divider busy periods, taken branches, exceptions and eret. Its state updates on the rising edge of clock, so its control outputs are stable before the pipeline registers latch on the falling edge.

Parameters:
MEM_WAIT_CYCLES, 2, stall cycles per memory/IO access in MEM (0 = no stall)
DIV_TIMEOUT, 40, maximum cycles spent in DIV_WAIT before forced exit

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
id_rs_address  in  5  rs of instruction in ID
id_rt_address  in  5  rt of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_memory_read  in  1  instruction in EX is a load
ex_write_back_address  in  5  destination register of instruction in EX
div_start  in  1  divide instruction in EX
div_done  in  1  divider result valid
mem_access  in  1  MEM-stage instruction does Memory_read/Memory_write/IO_read/IO_write
branch_taken  in  1  jump/branch resolved taken in MEM
exception  in  1  exception raised in MEM
eret  in  1  eret in MEM
pc_write  out  1  PC update enable
if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  register write enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble (all-zero) into register
pc_select  out  2  0 = PC+4, 1 = branch target, 2 = exception vector, 3 = EPC
state  out  2  0 RUN, 1 MEM_WAIT, 2 DIV_WAIT, 3 EXC_FLUSH
div_timeout  out  1  sticky: divider exceeded DIV_TIMEOUT

Behaviour:
- Registered: state, wait counter, div counter, mem_done, div_timeout. Control outputs are combinational from state and inputs.
- Default outputs (no event): all *_write=1, all *_flush=0, pc_select=0.
- Reset low at a clock edge: state=RUN, counters=0, mem_done=0, div_timeout=0. This applies in any state and aborts any wait.
- While reset is low, outputs are forced to: all *_write=0, all *_flush=1, pc_select=0.
- Priority in RUN, highest first: exception > eret > branch_taken > memory wait > divide wait > load-use.
- exception (any state): pc_select=2, pc_write=1, if_id_flush=id_ex_flush=ex_mem_flush=1. Next state EXC_FLUSH; any MEM_WAIT/DIV_WAIT is aborted and mem_done is cleared.
- EXC_FLUSH: lasts exactly 1 cycle. if_id_flush=1, pc_select=0, then RUN. An exception in this cycle re-enters EXC_FLUSH.
- eret (RUN): pc_select=3, same three flushes, stay in RUN.
- branch_taken (RUN): pc_select=1, same three flushes, stay in RUN.
- In MEM_WAIT/DIV_WAIT, branch_taken and eret are ignored; the held instruction re-presents them after the stall.
- Memory wait trigger: RUN, mem_access=1, mem_done=0, MEM_WAIT_CYCLES>0.
  - Trigger cycle stalls: pc_write=if_id_write=id_ex_write=ex_mem_write=0, mem_wb_flush=1.
  - If MEM_WAIT_CYCLES=1: set mem_done and stay in RUN.
  - Otherwise: enter MEM_WAIT with counter=MEM_WAIT_CYCLES-2.
- MEM_WAIT: same stall outputs. If counter==0, go to RUN and set mem_done; otherwise decrement.
- mem_done clears on the next cycle. Total stall = MEM_WAIT_CYCLES cycles, and the access is not retriggered.
- Divide wait trigger: RUN, div_start=1, div_done=0.
  - Stall outputs: pc_write=if_id_write=id_ex_write=0, ex_mem_flush=1.
  - Enter DIV_WAIT with div counter=1.
- DIV_WAIT: same stall outputs.
  - div_done=1: this cycle is not stalled, next state RUN.
  - Counter reaches DIV_TIMEOUT: set div_timeout and go to RUN.
  - Otherwise: counter increments. The counter is 6 bits and saturates.
- Load-use (RUN, no higher event) when ex_memory_read=1, ex_write_back_address!=0, and the address equals id_rs_address, or equals id_rt_address with id_uses_rt=1.
  - pc_write=if_id_write=0, id_ex_flush=1 for exactly one cycle, purely combinational.
  - Register $0 never causes a hazard.
- Simultaneous memory wait and load-use: the memory stall dominates, and the hazard is re-evaluated after it.

Test Plan:
- Load-use: ex_memory_read=1, ex_write_back_address=5, id_rs_address=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; repeat with address 0 -> no stall.
- Memory wait, MEM_WAIT_CYCLES=3: mem_access held high -> exactly 3 cycles of ex_mem_write=0 and mem_wb_flush=1, state sequence RUN, MEM_WAIT, MEM_WAIT, RUN, then no retrigger; repeat with MEM_WAIT_CYCLES=1 and 0 -> 1 and 0 stall cycles.
- Divide: div_start=1, div_done asserted 10 cycles later -> 10 stall cycles with ex_mem_flush=1; with div_done never asserted -> exit after 40 cycles, div_timeout=1 until reset.
- Exception during MEM_WAIT -> same cycle pc_select=2 and three flushes; next cycle state=3 with if_id_flush=1; then RUN, mem_done=0.
- Branch and load-use together -> pc_select=1, three flushes, pc_write=1, no load-use stall.
- reset low mid-DIV_WAIT -> all *_write=0 and all *_flush=1 while low; after the edge state=0, div_timeout=0; release -> default outputs.

Source files
------------

// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller
//   Stall/flush sequencer for the five-stage pipeline. Drives the write-enable
//   and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and
//   selects the PC source. It handles load-use hazards, multi-cycle memory/IO
//   accesses, divider busy periods, taken branches, exceptions and eret.
//   State updates on the rising clock edge, so the control outputs are stable
//   before the pipeline registers latch on the falling edge.
//
// Ports:
//   clock, reset                 clock, synchronous active-low reset
//   id_rs/rt_address, id_uses_rt source registers of the instruction in ID
//   ex_memory_read, ex_write_back_address  load in EX and its destination
//   div_start, div_done          divide in EX / divider result valid
//   mem_access                   MEM-stage instruction touches memory or IO
//   branch_taken, exception, eret  control-flow events resolved in MEM
//   pc_write, *_write, *_flush   pipeline register controls
//   pc_select                    0 PC+4, 1 branch target, 2 exc vector, 3 EPC
//   state                        0 RUN, 1 MEM_WAIT, 2 DIV_WAIT, 3 EXC_FLUSH
//   div_timeout                  sticky divider-timeout flag (cleared by reset)
// ---------------------------------------------------------------------------
module pipeline_controller #(
    parameter int MEM_WAIT_CYCLES = 2,
    parameter int DIV_TIMEOUT     = 40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] id_rs_address,
    input  logic [4:0] id_rt_address,
    input  logic       id_uses_rt,
    input  logic       ex_memory_read,
    input  logic [4:0] ex_write_back_address,
    input  logic       div_start,
    input  logic       div_done,
    input  logic       mem_access,
    input  logic       branch_taken,
    input  logic       exception,
    input  logic       eret,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       id_ex_write,
    output logic       ex_mem_write,
    output logic       mem_wb_write,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       mem_wb_flush,
    output logic [1:0] pc_select,
    output logic [1:0] state,
    output logic       div_timeout
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        DIV_WAIT  = 2'd2,
        EXC_FLUSH = 2'd3
    } state_t;

    // The trigger cycle is the first stall cycle, so MEM_WAIT only has to
    // count the remaining MEM_WAIT_CYCLES-1 cycles (counter runs down to 0).
    localparam int WAIT_W = (MEM_WAIT_CYCLES > 2) ? $clog2(MEM_WAIT_CYCLES - 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT =
        (MEM_WAIT_CYCLES >= 2) ? WAIT_W'(MEM_WAIT_CYCLES - 2) : '0;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [5:0]        div_cnt_q, div_cnt_d;
    logic              mem_done_q, mem_done_d;
    logic              div_timeout_q, div_timeout_d;
    logic              load_use;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            div_cnt_q     <= '0;
            mem_done_q    <= 1'b0;
            div_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            div_cnt_q     <= div_cnt_d;
            mem_done_q    <= mem_done_d;
            div_timeout_q <= div_timeout_d;
        end
    end

    // Register $0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = ex_memory_read && (ex_write_back_address != 5'd0) &&
                      ((ex_write_back_address == id_rs_address) ||
                       (id_uses_rt && (ex_write_back_address == id_rt_address)));

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        mem_wb_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_flush  = 1'b0;
        pc_select     = 2'd0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        div_cnt_d     = div_cnt_q;
        mem_done_d    = 1'b0;    // mem_done lives for exactly one cycle
        div_timeout_d = div_timeout_q;

        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (exception) begin
            // Valid in every state: aborts any wait in progress.
            pc_select    = 2'd2;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = EXC_FLUSH;
            wait_cnt_d   = '0;
            div_cnt_d    = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (eret || branch_taken) begin
                        pc_select    = eret ? 2'd3 : 2'd1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (mem_access && !mem_done_q && (MEM_WAIT_CYCLES > 0)) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
                        if (MEM_WAIT_CYCLES == 1) begin
                            mem_done_d = 1'b1;
                        end else begin
                            state_d    = MEM_WAIT;
                            wait_cnt_d = WAIT_INIT;
                        end
                    end else if (div_start && !div_done) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        state_d      = DIV_WAIT;
                        div_cnt_d    = 6'd1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_flush = 1'b1;
                    if (wait_cnt_q == '0) begin
                        state_d    = RUN;
                        mem_done_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 1'b1;
                    end
                end
                DIV_WAIT: begin
                    if (div_done) begin
                        state_d   = RUN;
                        div_cnt_d = '0;
                    end else begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        if (int'(div_cnt_q) >= DIV_TIMEOUT) begin
                            div_timeout_d = 1'b1;
                            state_d       = RUN;
                            div_cnt_d     = '0;
                        end else if (div_cnt_q != '1) begin
                            div_cnt_d = div_cnt_q + 6'd1;
                        end
                    end
                end
                EXC_FLUSH: begin
                    if_id_flush = 1'b1;
                    state_d     = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign state       = state_q;
    assign div_timeout = div_timeout_q;

endmodule
